// File: rtl/riscv_regfile_sb.sv
// Parametrised integer register file with two write ports, optional write-to-read
// bypass and a per-register pending-write scoreboard for multi-cycle producers.
module riscv_regfile_sb #(
    parameter int unsigned              XLEN     = 32,
    parameter int unsigned              NREGS    = 32,
    parameter int unsigned              NRD      = 2,
    parameter int unsigned              SP_INDEX = 2,
    parameter logic [XLEN-1:0]          SP_RESET = XLEN'(32'h8000_0000),
    parameter int unsigned              BYPASS   = 1,
    localparam int unsigned             AW       = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NRD*AW-1:0]           rs_addr,
    output logic [NRD*XLEN-1:0]         rs_data,
    output logic [NRD-1:0]              rs_busy,
    input  logic                        wr0_en,
    input  logic [AW-1:0]               wr0_rd,
    input  logic [XLEN-1:0]             wr0_data,
    input  logic                        wr1_en,
    input  logic [AW-1:0]               wr1_rd,
    input  logic [XLEN-1:0]             wr1_data,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_rd,
    input  logic                        flush,
    output logic [AW:0]                 pend_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_pend_cnt;

    logic             w_wr0_hit;
    logic             w_wr1_hit;
    logic             w_rsv_hit;
    logic             w_inc;
    logic             w_rel0;
    logic             w_rel1;
    logic [NREGS-1:0] w_pend_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic [AW-1:0]    w_addr [NRD];

    // Qualified requests; register 0 is never a target and nothing forwards in reset.
    assign w_wr0_hit = rst_n && wr0_en && (wr0_rd != '0);
    assign w_wr1_hit = rst_n && wr1_en && (wr1_rd != '0);
    assign w_rsv_hit = rst_n && rsv_en && (rsv_rd != '0) && !flush;

    // Register array; wr1 is issued last so it wins a same-destination collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
        end else begin
            if (w_wr0_hit && !(w_wr1_hit && (wr1_rd == wr0_rd))) begin
                r_regs[wr0_rd] <= wr0_data;
            end
            if (w_wr1_hit) begin
                r_regs[wr1_rd] <= wr1_data;
            end
        end
    end

    // Scoreboard next state: flush clears all, a reserve overrides a same-cycle release.
    always_comb begin
        w_pend_nxt = r_pend;
        if (flush) begin
            w_pend_nxt = '0;
        end else begin
            if (w_wr0_hit) begin
                w_pend_nxt[wr0_rd] = 1'b0;
            end
            if (w_wr1_hit) begin
                w_pend_nxt[wr1_rd] = 1'b0;
            end
            if (w_rsv_hit) begin
                w_pend_nxt[rsv_rd] = 1'b1;
            end
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Incremental count: each distinct pending register released counts once.
    always_comb begin
        w_inc  = w_rsv_hit && !r_pend[rsv_rd];
        w_rel0 = w_wr0_hit && r_pend[wr0_rd] && !(w_rsv_hit && (rsv_rd == wr0_rd));
        w_rel1 = w_wr1_hit && r_pend[wr1_rd] && !(w_rsv_hit && (rsv_rd == wr1_rd))
                 && !(w_wr0_hit && (wr0_rd == wr1_rd));
        if (flush) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_pend_cnt + (AW+1)'(w_inc) - (AW+1)'(w_rel0) - (AW+1)'(w_rel1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    assign pend_cnt = r_pend_cnt;

    // Zero-latency read ports with optional forwarding from the write ports.
    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            w_addr[i]                = rs_addr[i*AW +: AW];
            rs_data[i*XLEN +: XLEN]  = r_regs[w_addr[i]];
            rs_busy[i]               = r_pend[w_addr[i]];
            if ((BYPASS != 0) && (w_addr[i] != '0)) begin
                if (w_wr0_hit && (wr0_rd == w_addr[i])) begin
                    rs_data[i*XLEN +: XLEN] = wr0_data;
                    rs_busy[i]              = 1'b0;
                end
                if (w_wr1_hit && (wr1_rd == w_addr[i])) begin
                    rs_data[i*XLEN +: XLEN] = wr1_data;
                    rs_busy[i]              = 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: bypassing and non-bypassing instances share
// stimulus and are compared every cycle against an array-based reference model.
module tb_riscv_regfile_sb;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned AW    = 5;
    localparam logic [XLEN-1:0] SP_VAL = 32'h8000_0000;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NRD*AW-1:0]      rs_addr = '0;
    logic                   wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0, flush = 1'b0;
    logic [AW-1:0]          wr0_rd = '0, wr1_rd = '0, rsv_rd = '0;
    logic [XLEN-1:0]        wr0_data = '0, wr1_data = '0;

    logic [NRD*XLEN-1:0]    data_b, data_n;
    logic [NRD-1:0]         busy_b, busy_n;
    logic [AW:0]            cnt_b, cnt_n;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_pend;

    always #5 clk = ~clk;

    riscv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_INDEX(2),
                       .SP_RESET(SP_VAL), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(data_b), .rs_busy(busy_b),
        .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush), .pend_cnt(cnt_b));

    riscv_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .SP_INDEX(2),
                       .SP_RESET(SP_VAL), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(data_n), .rs_busy(busy_n),
        .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .flush(flush), .pend_cnt(cnt_n));

    // Reference model: per-register rules, count derived from the pending set.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] <= (r == 2) ? SP_VAL : '0;
                m_pend[r] <= 1'b0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (wr1_en && wr1_rd == AW'(r))      m_regs[r] <= wr1_data;
                else if (wr0_en && wr0_rd == AW'(r)) m_regs[r] <= wr0_data;
                if (flush)                                m_pend[r] <= 1'b0;
                else if (rsv_en && rsv_rd == AW'(r))      m_pend[r] <= 1'b1;
                else if ((wr0_en && wr0_rd == AW'(r)) ||
                         (wr1_en && wr1_rd == AW'(r)))    m_pend[r] <= 1'b0;
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && rst_n && wr1_en && wr1_rd == a) return wr1_data;
        if (byp && rst_n && wr0_en && wr0_rd == a) return wr0_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && rst_n && ((wr1_en && wr1_rd == a) || (wr0_en && wr0_rd == a))) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NRD; i++) begin
                chk("cyc_b_data", 64'(data_b[i*XLEN +: XLEN]), 64'(exp_data(rs_addr[i*AW +: AW], 1'b1)));
                chk("cyc_n_data", 64'(data_n[i*XLEN +: XLEN]), 64'(exp_data(rs_addr[i*AW +: AW], 1'b0)));
                chk("cyc_b_busy", 64'(busy_b[i]), 64'(exp_busy(rs_addr[i*AW +: AW], 1'b1)));
                chk("cyc_n_busy", 64'(busy_n[i]), 64'(exp_busy(rs_addr[i*AW +: AW], 1'b0)));
            end
            chk("cyc_b_cnt", 64'(cnt_b), 64'($countones(m_pend)));
            chk("cyc_n_cnt", 64'(cnt_n), 64'($countones(m_pend)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic reserve(input logic [AW-1:0] r);
        set_idle(); rsv_en = 1'b1; rsv_rd = r; step(); set_idle();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        set_rd(5'd2, 5'd5);
        #1;
        chk("rst_sp", 64'(data_b[31:0]), 64'h8000_0000);
        chk("rst_r5", 64'(data_b[63:32]), 64'h0);
        chk("rst_busy", 64'({busy_b, busy_n}), 64'h0);
        chk("rst_cnt", 64'(cnt_b), 64'h0);
        #5 rst_n = 1'b1;
        chk_on = 1'b1;
        step();

        // Same-destination collision: wr1 wins; bypass shows it before the edge
        wr0_en = 1; wr0_rd = 5; wr0_data = 32'h1111;
        wr1_en = 1; wr1_rd = 5; wr1_data = 32'h2222;
        set_rd(5'd5, 5'd0);
        #1;
        chk("prio_byp", 64'(data_b[31:0]), 64'h2222);
        chk("prio_nobyp", 64'(data_n[31:0]), 64'h0);
        step(); set_idle(); #1;
        chk("prio_after", 64'({data_b[31:0], data_n[31:0]}), {32'h2222, 32'h2222});

        wr1_en = 1; wr1_rd = 0; wr1_data = 32'hFFFF_FFFF; set_rd(5'd0, 5'd0);
        step(); set_idle(); #1;
        chk("x0_zero", 64'({data_b[31:0], data_n[31:0]}), 64'h0);

        wr0_en = 1; wr0_rd = 7; wr0_data = 32'hDEAD_BEEF; set_rd(5'd7, 5'd0);
        #1;
        chk("byp_fwd", 64'(data_b[31:0]), 64'hDEAD_BEEF);
        chk("byp_off_old", 64'(data_n[31:0]), 64'h0);
        step(); set_idle(); #1;
        chk("byp_off_new", 64'(data_n[31:0]), 64'hDEAD_BEEF);

        set_rd(5'd9, 5'd0);
        reserve(5'd9); #1;
        chk("rsv_busy", 64'({busy_b[0], busy_n[0]}), 64'h3);
        chk("rsv_cnt", 64'(cnt_b), 64'h1);
        wr0_en = 1; wr0_rd = 9; wr0_data = 32'h99; #1;
        chk("rel_busy_byp", 64'(busy_b[0]), 64'h0);
        chk("rel_busy_nobyp", 64'(busy_n[0]), 64'h1);
        step(); set_idle(); #1;
        chk("rel_cnt", 64'(cnt_b), 64'h0);
        rsv_en = 1; rsv_rd = 9; wr1_en = 1; wr1_rd = 9; wr1_data = 32'h77;
        step(); set_idle(); #1;
        chk("rsv_beats_wr", 64'({busy_b[0], busy_n[0]}), 64'h3);
        chk("rsv_beats_cnt", 64'(cnt_n), 64'h1);
        flush = 1; step(); set_idle();

        reserve(5'd3); reserve(5'd4); reserve(5'd5); #1;
        chk("cnt3", 64'(cnt_b), 64'h3);
        flush = 1; rsv_en = 1; rsv_rd = 6; set_rd(5'd6, 5'd3);
        step(); set_idle(); #1;
        chk("flush_cnt", 64'({cnt_b, cnt_n}), 64'h0);
        chk("flush_busy", 64'({busy_b, busy_n}), 64'h0);

        reserve(5'd3); reserve(5'd4);
        wr0_en = 1; wr0_rd = 3; wr0_data = 32'h3; wr1_en = 1; wr1_rd = 4; wr1_data = 32'h4;
        step(); set_idle(); #1;
        chk("dual_rel_cnt", 64'(cnt_b), 64'h0);

        reserve(5'd3); reserve(5'd4); reserve(5'd5); reserve(5'd6); #1;
        chk("cnt4", 64'(cnt_b), 64'h4);
        wr0_en = 1; wr0_rd = 2; wr0_data = 32'h1234; wr1_en = 1; wr1_rd = 8; wr1_data = 32'h5678;
        set_rd(5'd2, 5'd8);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", 64'({cnt_b, cnt_n}), 64'h0);
        chk("mid_rst_sp", 64'(data_b[31:0]), 64'h8000_0000);
        step(); rst_n = 1'b1; set_idle(); #1;
        chk("mid_rst_sp_after", 64'(data_b[31:0]), 64'h8000_0000);
        chk("mid_rst_r8", 64'(data_n[63:32]), 64'h0);

        // Randomized phase with collisions biased onto a small register set
        for (int n = 0; n < 3000; n++) begin
            step();
            wr0_en = ($urandom_range(0, 1) == 1);
            wr1_en = ($urandom_range(0, 1) == 1);
            rsv_en = ($urandom_range(0, 9) < 3);
            flush  = ($urandom_range(0, 39) == 0);
            wr0_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wr1_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            rsv_rd = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
